// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Instruction fetch front end. Drives the write side of the external
//   ProgramCounter (NextPC / PCWr), fetches the word at the current PC over a
//   req/ready instruction-memory handshake, and hands the fetched instruction
//   to decode over a valid/ready handshake. Execute can redirect the stream
//   (branch/jump). A watchdog flags a memory that never answers.
//
// Ports
//   clk              clock, all state updates on the rising edge
//   reset            synchronous, active-high
//   PC               current PC from the ProgramCounter
//   NextPC           value the ProgramCounter loads when PCWr=1
//   PCWr             PC write enable, combinational one-cycle pulse
//   imem_req         fetch request
//   imem_addr        fetch address (equals PC while imem_req=1)
//   imem_ready       memory returns imem_rdata this cycle
//   imem_rdata       fetched word
//   instr_valid      instr / instr_pc hold a fetched instruction
//   instr_ready      decode accepts the instruction
//   instr            registered instruction
//   instr_pc         address instr was fetched from
//   redirect_valid   branch/jump taken
//   redirect_target  redirect destination (low two bits ignored)
//   fetch_err        sticky watchdog error, cleared only by reset
module pc_fetch_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] NextPC,
  output logic              PCWr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              fetch_err
);

  // TIMEOUT is limited to 1..255, so an 8-bit wait counter always suffices.
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               vld_p1;
  logic [DATA_W-1:0]  instr_p1;
  logic [ADDR_W-1:0]  instr_pc_p1;
  logic               err_p1;

  // Sequential increment; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

  // Redirect targets are word aligned by forcing the low two bits to zero.
  function automatic logic [ADDR_W-1:0] pc_align(input logic [ADDR_W-1:0] t);
    return {t[ADDR_W-1:2], 2'b00};
  endfunction

  logic in_req;
  logic in_hold;
  logic redirect_take;
  logic fetch_done;

  // Redirects only act while fetching or holding; reset masks everything so
  // the PC is never written in the reset cycle.
  assign in_req        = (state == REQ);
  assign in_hold       = (state == HOLD);
  assign redirect_take = !reset && redirect_valid && (in_req || in_hold);
  assign fetch_done    = !reset && in_req && imem_ready && !redirect_valid;

  assign PCWr      = redirect_take || fetch_done;
  assign NextPC    = redirect_take ? pc_align(redirect_target) : pc_incr(PC);
  assign imem_req  = !reset && in_req;
  assign imem_addr = PC;

  assign instr_valid = vld_p1;
  assign instr       = instr_p1;
  assign instr_pc    = instr_pc_p1;
  assign fetch_err   = err_p1;

  // Fetch -> decode register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      vld_p1      <= 1'b0;
      instr_p1    <= '0;
      instr_pc_p1 <= '0;
      err_p1      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
        end

        REQ: begin
          if (redirect_valid) begin
            // Any word returned this cycle belongs to the old stream.
            wait_cnt <= '0;
          end else if (imem_ready) begin
            instr_p1    <= imem_rdata;
            instr_pc_p1 <= PC;
            wait_cnt    <= '0;
            vld_p1      <= 1'b1;
            state       <= HOLD;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            // The counter reaches TIMEOUT on this edge with no answer.
            if (wait_cnt == WAIT_LAST) begin
              err_p1 <= 1'b1;
              state  <= ERR;
            end
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            // Squash (or, with instr_ready, retire) and refetch the target.
            vld_p1   <= 1'b0;
            wait_cnt <= '0;
            state    <= REQ;
          end else if (instr_ready) begin
            // PC already advanced when the fetch completed.
            vld_p1 <= 1'b0;
            state  <= REQ;
          end
        end

        ERR: begin
          state <= ERR;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Testbench for pc_fetch_sequencer: directed scenarios followed by a
// randomized run checked against a behavioural model of the fetch rules.
// The bench also plays the ProgramCounter (loads NextPC when PCWr=1).
module tb_pc_fetch_sequencer;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic              pcwr;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .PC(pc), .NextPC(next_pc), .PCWr(pcwr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .fetch_err(fetch_err)
  );

  // One clock: capture the PC write request, take the edge, then load the PC
  // 1 time unit later so the DUT samples the old value at the edge.
  task automatic tick();
    logic              w;
    logic [ADDR_W-1:0] np;
    w  = pcwr;
    np = next_pc;
    @(posedge clk);
    #1;
    if (w) pc = np;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    pc = 32'h0; imem_ready = 1'b1; instr_ready = 1'b1; imem_rdata = 32'hAABBCCDD;
    reset = 1'b1; redirect_valid = 1'b0;
    #1;
    n_checks++; if (pcwr !== 1'b0) begin n_fail++; $display("FAIL reset_pcwr: got %b want 0", pcwr); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_checks++; if (next_pc !== 32'h4) begin n_fail++; $display("FAIL reset_nextpc: got %h want 00000004", next_pc); end
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_checks++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
    n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", fetch_err); end
    n_checks++; if (imem_req !== 1'b0 || pcwr !== 1'b0) begin n_fail++; $display("FAIL idle_outputs: req=%b pcwr=%b want 0 0", imem_req, pcwr); end
  endtask

  task automatic test_stream();
    int nvalid;
    tick(); #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL stream_req: req=%b addr=%h want 1 00000000", imem_req, imem_addr); end
    n_checks++; if (pcwr !== 1'b1 || next_pc !== 32'h4) begin n_fail++; $display("FAIL stream_pcwr: pcwr=%b nextpc=%h want 1 00000004", pcwr, next_pc); end
    tick(); #1;
    n_checks++; if (instr_valid !== 1'b1 || instr !== 32'hAABBCCDD) begin n_fail++; $display("FAIL stream_instr: valid=%b instr=%h want 1 aabbccdd", instr_valid, instr); end
    n_checks++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL stream_instr_pc: got %h want 0", instr_pc); end
    n_checks++; if (pcwr !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL stream_hold: pcwr=%b req=%b want 0 0", pcwr, imem_req); end
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      if (instr_valid === 1'b1) nvalid++;
    end
    n_checks++; if (nvalid != 5) begin n_fail++; $display("FAIL stream_rate: got %0d valid cycles want 5", nvalid); end
    n_checks++; if (pc !== 32'd24 || instr_pc !== 32'd20) begin n_fail++; $display("FAIL stream_pc: pc=%h instr_pc=%h want 18 14", pc, instr_pc); end
  endtask

  task automatic test_backpressure();
    pc = 32'h100; imem_ready = 1'b1; instr_ready = 1'b0; imem_rdata = 32'h12345678;
    do_reset();
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      imem_rdata = $urandom;
      #1;
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h12345678 || instr_pc !== 32'h100 || imem_req !== 1'b0 || pcwr !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: valid=%b instr=%h ipc=%h req=%b pcwr=%b want 1 12345678 100 0 0", instr_valid, instr, instr_pc, imem_req, pcwr);
      end
      tick();
    end
    instr_ready = 1'b1; imem_ready = 1'b0;
    tick(); #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: req=%b addr=%h valid=%b want 1 104 0", imem_req, imem_addr, instr_valid); end
  endtask

  task automatic test_redirect();
    pc = 32'h2000; imem_ready = 1'b0; instr_ready = 1'b0;
    do_reset();
    tick();
    imem_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h00400103; imem_rdata = 32'h11111111;
    #1;
    n_checks++; if (pcwr !== 1'b1 || next_pc !== 32'h00400100) begin n_fail++; $display("FAIL redir_req_pc: pcwr=%b nextpc=%h want 1 00400100", pcwr, next_pc); end
    tick();
    redirect_valid = 1'b0; imem_ready = 1'b0;
    #1;
    n_checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin n_fail++; $display("FAIL redir_discard: valid=%b instr=%h want 0 0", instr_valid, instr); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h00400100) begin n_fail++; $display("FAIL redir_refetch: req=%b addr=%h want 1 00400100", imem_req, imem_addr); end
    imem_ready = 1'b1; imem_rdata = 32'h22222222;
    tick(); #1;
    n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h22222222 || instr_pc !== 32'h00400100) begin n_fail++; $display("FAIL redir_fetch: valid=%b instr=%h ipc=%h want 1 22222222 00400100", instr_valid, instr, instr_pc); end
    redirect_valid = 1'b1; redirect_target = 32'h0000000B;
    #1;
    n_checks++; if (pcwr !== 1'b1 || next_pc !== 32'h8) begin n_fail++; $display("FAIL redir_hold_pc: pcwr=%b nextpc=%h want 1 00000008", pcwr, next_pc); end
    tick();
    redirect_valid = 1'b0; imem_ready = 1'b0;
    #1;
    n_checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL redir_squash: valid=%b req=%b addr=%h want 0 1 8", instr_valid, imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    pc = 32'hFFFFFFFC; imem_ready = 1'b1; instr_ready = 1'b1;
    do_reset();
    tick(); #1;
    n_checks++; if (pcwr !== 1'b1 || next_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_nextpc: pcwr=%b nextpc=%h want 1 0", pcwr, next_pc); end
    tick(); #1;
    n_checks++; if (pc !== 32'h0 || instr_pc !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_pc: pc=%h ipc=%h want 0 fffffffc", pc, instr_pc); end
  endtask

  task automatic test_timeout();
    int bad;
    pc = 32'h40; imem_ready = 1'b0; instr_ready = 1'b1;
    do_reset();
    tick();
    bad = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      #1;
      if (imem_req !== 1'b1 || fetch_err !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL to_wait: %0d bad waiting cycles want 0", bad); end
    #1;
    n_checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL to_err: err=%b req=%b want 1 0", fetch_err, imem_req); end
    redirect_valid = 1'b1; redirect_target = 32'h80; imem_ready = 1'b1;
    #1;
    n_checks++; if (pcwr !== 1'b0 || next_pc !== 32'h44) begin n_fail++; $display("FAIL to_redirect: pcwr=%b nextpc=%h want 0 44", pcwr, next_pc); end
    tick(); #1;
    n_checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h40) begin n_fail++; $display("FAIL to_sticky: err=%b req=%b valid=%b pc=%h want 1 0 0 40", fetch_err, imem_req, instr_valid, pc); end
    redirect_valid = 1'b0; imem_ready = 1'b0;
    do_reset();
    #1;
    n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL to_clear: err=%b want 0", fetch_err); end
    tick(); #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL to_restart: req=%b addr=%h want 1 40", imem_req, imem_addr); end
  endtask

  task automatic test_reset_in_hold();
    pc = 32'h300; imem_ready = 1'b1; instr_ready = 1'b0; imem_rdata = 32'h5A5A5A5A;
    do_reset();
    tick(); tick(); #1;
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL rh_valid: got %b want 1", instr_valid); end
    reset = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h1000;
    #1;
    n_checks++; if (pcwr !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rh_pcwr: pcwr=%b req=%b want 0 0", pcwr, imem_req); end
    tick();
    reset = 1'b0; redirect_valid = 1'b0;
    #1;
    n_checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || instr !== 32'h0) begin n_fail++; $display("FAIL rh_idle: valid=%b req=%b instr=%h want 0 0 0", instr_valid, imem_req, instr); end
    tick(); #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h304) begin n_fail++; $display("FAIL rh_restart: req=%b addr=%h want 1 304", imem_req, imem_addr); end
  endtask

  // Behavioural model: tracks whether the sequencer is just out of reset,
  // holding an instruction, or dead, plus how long the memory has ignored it.
  task automatic test_random();
    bit                m_idle, m_hold, m_err, stall, fetching, redir, e_req, e_pcwr;
    int                m_wait;
    logic [DATA_W-1:0] m_instr;
    logic [ADDR_W-1:0] m_ipc, e_np;
    pc = {$urandom} & ~32'h3;
    do_reset();
    m_idle = 1; m_hold = 0; m_err = 0; m_wait = 0; m_instr = '0; m_ipc = '0; stall = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) stall = !stall;
      reset           = ($urandom_range(0, 149) == 0);
      imem_ready      = stall ? 1'b0 : ($urandom_range(0, 2) != 0);
      instr_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid  = ($urandom_range(0, 9) == 0);
      redirect_target = $urandom;
      imem_rdata      = $urandom;
      #1;
      fetching = !m_idle && !m_hold && !m_err;
      redir    = !reset && redirect_valid && (fetching || m_hold);
      e_req    = !reset && fetching;
      e_pcwr   = redir || (!reset && fetching && imem_ready);
      e_np     = redir ? (redirect_target & ~32'h3) : pc + 32'd4;
      n_checks++; if (pcwr !== e_pcwr) begin n_fail++; $display("FAIL rnd_pcwr cyc %0d: got %b want %b", i, pcwr, e_pcwr); end
      n_checks++; if (next_pc !== e_np) begin n_fail++; $display("FAIL rnd_nextpc cyc %0d: got %h want %h", i, next_pc, e_np); end
      n_checks++; if (imem_req !== e_req) begin n_fail++; $display("FAIL rnd_req cyc %0d: got %b want %b", i, imem_req, e_req); end
      if (e_req) begin
        n_checks++; if (imem_addr !== pc) begin n_fail++; $display("FAIL rnd_addr cyc %0d: got %h want %h", i, imem_addr, pc); end
      end
      n_checks++; if (instr_valid !== m_hold) begin n_fail++; $display("FAIL rnd_valid cyc %0d: got %b want %b", i, instr_valid, m_hold); end
      n_checks++; if (fetch_err !== m_err) begin n_fail++; $display("FAIL rnd_err cyc %0d: got %b want %b", i, fetch_err, m_err); end
      if (m_hold) begin
        n_checks++; if (instr !== m_instr || instr_pc !== m_ipc) begin n_fail++; $display("FAIL rnd_instr cyc %0d: got %h@%h want %h@%h", i, instr, instr_pc, m_instr, m_ipc); end
      end
      if (reset) begin
        m_idle = 1; m_hold = 0; m_err = 0; m_wait = 0; m_instr = '0; m_ipc = '0;
      end else if (m_idle) begin
        m_idle = 0;
      end else if (m_err) begin
        m_err = 1;
      end else if (redir) begin
        m_hold = 0; m_wait = 0;
      end else if (m_hold) begin
        if (instr_ready) m_hold = 0;
      end else if (imem_ready) begin
        m_hold = 1; m_instr = imem_rdata; m_ipc = pc; m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait == TIMEOUT) m_err = 1;
      end
      tick();
    end
    reset = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; pc = '0; imem_ready = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_timeout();
    test_reset_in_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
